// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: FSM state encoding and ASCII constants
// used by the optional CR/LF expansion (UART_TXQ_CRLF_EN).
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_ACTIVE = 2'd2
   } txq_state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer stream and transmitter launch signals of the UART transmit queue.
// slave = queue side, master = producer/transmitter side.
interface uart_tx_queue_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          in_data;
   logic                in_valid;
   logic                in_ready;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic                tx_busy;
   logic [DEPTH_LOG2:0] level;
   logic                idle;

   modport slave (
      input  in_data, in_valid, tx_busy,
      output in_ready, tx_start, tx_data, level, idle
   );

   modport master (
      output in_data, in_valid, tx_busy,
      input  in_ready, tx_start, tx_data, level, idle
   );
endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous byte FIFO (uart_sync_fifo): storage array, wrapping pointers and occupancy level.
// Push is ignored when full and pop when empty, so level never over/underflows.
module uart_sync_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [7:0]            wdata_i,
   output logic [7:0]            rdata_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = LVL_ONE[DEPTH_LOG2-1:0];

   logic [7:0]            mem_q [0:(1 << DEPTH_LOG2) - 1];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  do_push_s;
   logic                  do_pop_s;

   assign full_o    = (level_q == LVL_FULL);
   assign empty_o   = (level_q == LVL_ZERO);
   assign level_o   = level_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;

   // Pointer and level next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {DEPTH_LOG2{1'b0}};
         rd_ptr_q <= {DEPTH_LOG2{1'b0}};
         level_q  <= LVL_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care while level says empty
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter; launches one byte per frame with a registered
// tx_start strobe. Optional macro UART_TXQ_CRLF_EN expands a queued LF into CR,LF on the wire.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_queue_if.slave bus
);
   txq_state_e          state_q, state_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                rdy_q;
   logic                push_s;
   logic                pop_s;
   logic [7:0]          head_s;
   logic [DEPTH_LOG2:0] level_s;
   logic                full_s;
   logic                empty_s;
`ifdef UART_TXQ_CRLF_EN
   logic                cr_done_q, cr_done_d;
`endif

   // No full bypass: a pop in the same cycle does not reopen in_ready
   assign bus.in_ready = rdy_q & ~full_s;
   assign push_s       = bus.in_valid & rdy_q & ~full_s;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.level    = level_s;
   assign bus.idle     = empty_s & (state_q == S_IDLE) & ~bus.tx_busy;

   uart_sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (bus.in_data),
      .rdata_o (head_s),
      .level_o (level_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Launch FSM next-state; the S_IDLE busy guard also covers a reset taken mid-frame
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop_s      = 1'b0;
`ifdef UART_TXQ_CRLF_EN
      cr_done_d  = cr_done_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!empty_s && !bus.tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = S_START;
`ifdef UART_TXQ_CRLF_EN
               if ((head_s == ASCII_LF) && !cr_done_q) begin
                  tx_data_d = ASCII_CR;
                  cr_done_d = 1'b1;
               end else begin
                  tx_data_d = head_s;
                  pop_s     = 1'b1;
                  cr_done_d = 1'b0;
               end
`else
               tx_data_d  = head_s;
               pop_s      = 1'b1;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (!bus.tx_busy) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ACTIVE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered transmitter outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         rdy_q      <= 1'b1;
      end
   end

`ifdef UART_TXQ_CRLF_EN
   // CR already sent for the LF at the head of the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_done_q <= 1'b0;
      end else begin
         cr_done_q <= cr_done_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue paired with a behavioural 8N1 transmitter and line receiver.
// Expected launches/wire bytes are queued at acceptance; monitors pop and compare.
module tb_uart_tx_queue;
   localparam int DL  = 4;
   localparam int CPB = 104;   // 12 MHz / 115200 baud

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH_LOG2(DL)) bus ();
   uart_tx_queue #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Transmitter model; deliberately not reset by rst_n
   logic       tb_busy = 1'b0;
   logic       hold_busy = 1'b0;
   logic       line = 1'b1;
   logic [9:0] sh = 10'h3FF;
   int         bitn = 0;
   int         cnt = 0;
   assign bus.tx_busy = tb_busy | hold_busy;

   always @(posedge clk) begin
      if (!tb_busy) begin
         if (bus.tx_start) begin
            sh      <= {1'b1, bus.tx_data, 1'b0};
            tb_busy <= 1'b1;
            bitn    <= 0;
            cnt     <= 0;
            line    <= 1'b0;
         end
      end else if (cnt == CPB - 1) begin
         cnt <= 0;
         if (bitn == 9) begin
            tb_busy <= 1'b0;
         end else begin
            bitn <= bitn + 1;
            line <= sh[bitn + 1];
         end
      end else begin
         cnt <= cnt + 1;
      end
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] launch_q[$];
   logic [7:0] wire_q[$];
   int   cyc = 0;
   int   fall_cyc = -1;
   logic prev_busy = 1'b0;
   logic gap_chk = 1'b0;
   logic rx_act = 1'b0;
   int   rx_cnt = 0;
   int   rx_bit = 0;
   logic [9:0] rx_frame = 10'h000;
   logic [9:0] last_frame = 10'h000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void sb_push(input logic [7:0] b);
`ifdef UART_TXQ_CRLF_EN
      if (b == 8'h0A) begin
         launch_q.push_back(8'h0D);
         wire_q.push_back(8'h0D);
      end
`endif
      launch_q.push_back(b);
      wire_q.push_back(b);
   endfunction

   // Monitor: launch scoreboard, back-to-back gap and serial receiver
   initial forever begin
      @(negedge clk);
      cyc++;
      if (prev_busy && !tb_busy) fall_cyc = cyc;
      prev_busy = tb_busy;
      if (bus.tx_start) begin
         if (gap_chk && fall_cyc >= 0) begin
            chk("b2b_gap", cyc - fall_cyc, 2);
            fall_cyc = -1;
         end
         if (launch_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: tx_start with data %02h, none expected", bus.tx_data);
         end else begin
            chk("launch_data", {24'h0, bus.tx_data}, {24'h0, launch_q.pop_front()});
         end
      end
      if (!rx_act) begin
         if (!line) begin
            rx_act = 1'b1;
            rx_cnt = CPB / 2;
            rx_bit = 0;
         end
      end else if (rx_cnt > 0) begin
         rx_cnt--;
      end else begin
         rx_frame[rx_bit] = line;
         if (rx_bit == 9) begin
            rx_act     = 1'b0;
            last_frame = rx_frame;
            chk("frame_bits", {30'h0, rx_frame[9], rx_frame[0]}, 32'h2);
            if (wire_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: byte %02h on wire, none expected", rx_frame[8:1]);
            end else begin
               chk("wire_byte", {24'h0, rx_frame[8:1]}, {24'h0, wire_q.pop_front()});
            end
         end else begin
            rx_bit++;
            rx_cnt = CPB - 1;
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: byte %02h not accepted within %0d cycles", b, n);
      end else begin
         @(posedge clk);
         sb_push(b);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.idle && n < 30000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {31'h0, bus.idle}, 32'h1);
   endtask

   task automatic wait_launch();
      int n;
      n = 0;
      while (!bus.tx_start && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("launch_seen", {31'h0, bus.tx_start}, 32'h1);
   endtask

`ifdef UART_TXQ_CRLF_EN
   int lvl_tab[$] = '{2, 2, 1, 0};
`else
   int lvl_tab[$] = '{2, 1, 0};
`endif

   initial begin
      int n;
      int drop;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // 1: reset state and in_ready one edge after release
      @(negedge clk);
      chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
      chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      chk("rst_level", {27'h0, bus.level}, 32'h0);
      chk("rst_idle", {31'h0, bus.idle}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_pre", {31'h0, bus.in_ready}, 32'h0);
      @(negedge clk);
      chk("rel_in_ready", {31'h0, bus.in_ready}, 32'h1);

      // 2: single byte latency and wire pattern
      push_byte(8'h55);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("lat_no_start", {31'h0, bus.tx_start}, 32'h0);
      chk("lat_level1", {27'h0, bus.level}, 32'h1);
      @(negedge clk);
      chk("lat_start", {31'h0, bus.tx_start}, 32'h1);
      chk("lat_data", {24'h0, bus.tx_data}, 32'h55);
      chk("lat_level0", {27'h0, bus.level}, 32'h0);
      wait_idle();
      chk("wire_55", {22'h0, last_frame}, {22'h0, 10'b1010101010});

      // 3: 17-byte burst against a stalled transmitter, then back-to-back drain
      fall_cyc  = -1;
      gap_chk   = 1'b1;
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(i[7:0]);
      @(negedge clk);
      bus.in_data = 8'h10;
      chk("full_level", {27'h0, bus.level}, 32'd16);
      chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
      hold_busy = 1'b0;
      push_byte(8'h10);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("refill_level", {27'h0, bus.level}, 32'd16);
      chk("refill_in_ready", {31'h0, bus.in_ready}, 32'h0);
      wait_idle();
      gap_chk = 1'b0;

      // 4: simultaneous push and pop at level 3
      hold_busy = 1'b1;
      push_byte(8'h21);
      push_byte(8'h22);
      push_byte(8'h23);
      @(negedge clk);
      bus.in_data = 8'h24;
      hold_busy   = 1'b0;
      chk("pp_level_before", {27'h0, bus.level}, 32'd3);
      @(posedge clk);
      sb_push(8'h24);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("pp_level_after", {27'h0, bus.level}, 32'd3);
      chk("pp_launch", {31'h0, bus.tx_start}, 32'h1);
      wait_idle();

      // 5: reset mid-frame with 5 bytes queued
      push_byte(8'h11);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!tb_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) push_byte(8'h61 + i[7:0]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mid_level5", {27'h0, bus.level}, 32'd5);
      @(negedge clk);
      rst_n = 1'b0;
      drop  = launch_q.size();
      for (int i = 0; i < drop; i++) void'(wire_q.pop_back());
      launch_q.delete();
      #1;
      chk("mid_rst_level", {27'h0, bus.level}, 32'h0);
      chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("mid_rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
      chk("mid_rst_idle", {31'h0, bus.idle}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_idle();
      chk("mid_after_level", {27'h0, bus.level}, 32'h0);

      // 6: LF handling (expanded to CR,LF when the macro is defined)
      hold_busy = 1'b1;
      push_byte(8'h41);
      push_byte(8'h0A);
      push_byte(8'h42);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("lf_level3", {27'h0, bus.level}, 32'd3);
      hold_busy = 1'b0;
      foreach (lvl_tab[i]) begin
         wait_launch();
         chk("lf_level_at_launch", {27'h0, bus.level}, lvl_tab[i]);
         @(negedge clk);
      end
      wait_idle();

      chk("launch_q_drained", launch_q.size(), 32'h0);
      chk("wire_q_drained", wire_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
